// File: rtl/latch_sched_pkg.sv
// Shared types and helpers for the latch-bank write scheduler and related array controllers.
package latch_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GATE  = 2'd2,
        HOLD  = 2'd3
    } sched_state_e;

    // Counter must hold GATE_CYC-1; keep at least one bit so GATE_CYC=1 still builds.
    function automatic int cnt_width(input int gate_cyc);
        return (gate_cyc > 1) ? $clog2(gate_cyc) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from valid and a registered priority pointer.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         valid_i,
    input  logic                    accept_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] grant_idx_o
);

    localparam int IW = $clog2(NREQ);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic          found;
    int            idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr_q) + k) % NREQ;
            if (!found && valid_i[idx]) begin
                found          = 1'b1;
                grant_o[idx]   = 1'b1;
                grant_idx_o    = IW'(idx);
            end
        end
    end

    // Pointer moves just past the winner so it becomes lowest priority next round.
    assign ptr_d = (grant_idx_o == IW'(NREQ - 1)) ? '0 : IW'(grant_idx_o + 1'b1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/latch_bank_wr_sched.sv
// Write scheduler for a bank of transparent-high latches: arbitrates, then drives setup/gate/hold on G and D.
module latch_bank_wr_sched
    import latch_sched_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int AW       = 3,
    parameter int DW       = 8,
    parameter int GATE_CYC = 1
) (
    input  logic                    CK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*AW-1:0]      req_addr,
    input  logic [NREQ*DW-1:0]      req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic [DW-1:0]           lat_d,
    output logic [(2**AW)-1:0]      lat_g,
    output logic                    busy,
    output logic [$clog2(NREQ)-1:0] grant_id
);

    localparam int ROWS = 2 ** AW;
    localparam int IW   = $clog2(NREQ);
    localparam int CW   = cnt_width(GATE_CYC);

    sched_state_e    state_q;
    logic [AW-1:0]   addr_q;
    logic [AW-1:0]   addr_d;
    logic [DW-1:0]   lat_d_q;
    logic [DW-1:0]   data_d;
    logic [ROWS-1:0] lat_g_q;
    logic [ROWS-1:0] row_sel_d;
    logic [IW-1:0]   gid_q;
    logic [IW-1:0]   gidx;
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] arb_valid;
    logic [NREQ-1:0] grant;
    logic            xfer;

    // No grant while a write is in flight or while reset is being applied.
    assign arb_valid = (state_q == IDLE && !RST) ? req_valid : '0;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk_i      (CK),
        .rst_i      (RST),
        .valid_i    (arb_valid),
        .accept_i   (xfer),
        .grant_o    (grant),
        .grant_idx_o(gidx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        addr_d = '0;
        data_d = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                addr_d = req_addr[k*AW +: AW];
                data_d = req_data[k*DW +: DW];
            end
        end
    end

    assign row_sel_d = {{(ROWS-1){1'b0}}, 1'b1} << addr_q;

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
            lat_d_q <= '0;
            lat_g_q <= '0;
            gid_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer) begin
                        addr_q  <= addr_d;
                        lat_d_q <= data_d;
                        gid_q   <= gidx;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    cnt_q   <= CW'(GATE_CYC - 1);
                    lat_g_q <= row_sel_d;
                    state_q <= GATE;
                end
                GATE: begin
                    if (cnt_q == '0) begin
                        lat_g_q <= '0;
                        state_q <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                HOLD: begin
                    state_q <= IDLE;
                end
                default: begin
                    lat_g_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lat_d    = lat_d_q;
    assign lat_g    = lat_g_q;
    assign busy     = (state_q != IDLE);
    assign grant_id = gid_q;

endmodule

// File: tb/tb_latch_bank_wr_sched.sv
// Scoreboard bench for latch_bank_wr_sched: cycle-timeline reference model plus grant queue checked at G rise.
module tb_latch_bank_wr_sched;

    localparam int NREQ = 4;
    localparam int AW   = 3;
    localparam int DW   = 8;
    localparam int GC   = 3;
    localparam int ROWS = 8;
    localparam int IW   = 2;

    logic                 CK = 1'b0;
    logic                 RST = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ*AW-1:0]   req_addr = '0;
    logic [NREQ*DW-1:0]   req_data = '0;
    logic [NREQ-1:0]      req_ready;
    logic [DW-1:0]        lat_d;
    logic [ROWS-1:0]      lat_g;
    logic                 busy;
    logic [IW-1:0]        grant_id;

    latch_bank_wr_sched #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .GATE_CYC(GC)
    ) dut (
        .CK(CK), .RST(RST), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .lat_d(lat_d),
        .lat_g(lat_g), .busy(busy), .grant_id(grant_id)
    );

    always #5 CK = ~CK;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    txn_t q[$];
    int total = 0;
    int bad = 0;
    int to_req = 0;
    int to_seen = 0;
    logic [NREQ-1:0] last_xfer = '0;

    // Reference model state: cycle of last grant and what was granted.
    int              c = 0;
    int              g = -1000;
    int              m_ptr = 0;
    logic [AW-1:0]   m_addr = '0;
    logic [IW-1:0]   m_id = '0;
    logic [DW-1:0]   latd_exp = '0;
    bit              armed = 1'b0;
    bit              prev_rst = 1'b0;
    logic [ROWS-1:0] prev_g = '0;
    logic [DW-1:0]   prev_d = '0;
    int              glen = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, exp);
        end
    endtask

    always @(negedge CK) begin : mon
        logic [NREQ-1:0] exp_rdy;
        logic [ROWS-1:0] exp_g;
        int              w;
        int              idx;
        txn_t            t;
        exp_rdy = '0;
        w = -1;
        if (to_req != to_seen) begin
            total++;
            bad++;
            $display("FAIL timeout waiting for grant/gate cyc=%0d actual=none required=event", c);
            to_seen = to_req;
        end
        if (!RST && c >= g + GC + 3) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (w < 0 && req_valid[idx]) w = idx;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        exp_g = (c >= g + 2 && c <= g + GC + 1) ? (ROWS'(1) << m_addr) : '0;
        if (armed) begin
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("busy", 64'(busy), 64'(c > g && c <= g + GC + 2));
            chk("lat_g", 64'(lat_g), 64'(exp_g));
            chk("lat_d", 64'(lat_d), 64'(latd_exp));
            if (c > g && c <= g + GC + 2) chk("grant_id", 64'(grant_id), 64'(m_id));
            chk("lat_g_onehot", 64'($countones(lat_g) <= 1), 64'(1));
            if (lat_g != '0 && prev_g == '0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected_gate cyc=%0d actual=%0h required=none", c, lat_g);
                end else begin
                    t = q.pop_front();
                    chk("sb_row", 64'(lat_g), 64'(ROWS'(1) << t.addr));
                    chk("sb_data", 64'(lat_d), 64'(t.data));
                    chk("sb_id", 64'(grant_id), 64'(t.id));
                end
            end
            if (lat_g == '0 && prev_g != '0 && !prev_rst) chk("gate_len", 64'(glen), 64'(GC));
            if (!prev_rst && (lat_g != '0 || prev_g != '0)) chk("lat_d_stable", 64'(lat_d), 64'(prev_d));
        end
        glen     = (lat_g != '0) ? glen + 1 : 0;
        prev_g   = lat_g;
        prev_d   = lat_d;
        prev_rst = RST;
        if (RST) begin
            armed    = 1'b1;
            g        = -1000;
            m_ptr    = 0;
            latd_exp = '0;
            glen     = 0;
            q.delete();
        end else if (w >= 0) begin
            g        = c;
            m_id     = IW'(w);
            m_addr   = req_addr[w*AW +: AW];
            latd_exp = req_data[w*DW +: DW];
            m_ptr    = (w + 1) % NREQ;
            q.push_back('{id: IW'(w), addr: req_addr[w*AW +: AW], data: req_data[w*DW +: DW]});
        end
        c++;
    end

    task automatic tick();
        @(negedge CK);
        last_xfer = req_valid & req_ready;
        @(posedge CK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = 1'b1;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic wait_xfer(input int i);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_xfer[i] && n < 50);
        if (!last_xfer[i]) to_req++;
    endtask

    initial begin
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;

        // single write: requester 0, row 3, A5
        set_req(0, 3'd3, 8'hA5);
        wait_xfer(0);
        req_valid[0] = 1'b0;
        repeat (GC + 4) tick();

        // all four valid continuously
        for (int i = 0; i < NREQ; i++) set_req(i, AW'(2 * i + 1), DW'($urandom));
        for (int n = 0; n < 12 * (GC + 3); n++) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if (last_xfer[i]) set_req(i, AW'(i + n), DW'($urandom));
        end
        req_valid = '0;
        repeat (GC + 4) tick();

        // pointer to 3, then valid=0101 wraps to 0 and requester 2 withdraws
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_req(k, AW'(k + 4), DW'($urandom));
            wait_xfer(k);
            req_valid[k] = 1'b0;
        end
        set_req(0, 3'd2, 8'h5A);
        set_req(2, 3'd7, 8'h77);
        wait_xfer(0);
        req_valid = '0;
        repeat (GC + 6) tick();

        // reset mid-GATE; pointer would be 3 without the reset, so 2 must win over 3
        set_req(2, 3'd1, 8'h11);
        wait_xfer(2);
        req_valid = '0;
        begin
            int n;
            n = 0;
            while (lat_g == '0 && n < 20) begin
                tick();
                n++;
            end
            if (lat_g == '0) to_req++;
        end
        set_req(2, 3'd6, 8'h3C);
        set_req(3, 3'd7, 8'hC3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        wait_xfer(2);
        req_valid[2] = 1'b0;
        wait_xfer(3);
        req_valid = '0;
        repeat (GC + 6) tick();

        // random traffic with withdrawals and occasional resets
        for (int n = 0; n < 1500; n++) begin
            tick();
            RST = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (last_xfer[i] || !req_valid[i]) begin
                    if ($urandom_range(0, 1) == 1) set_req(i, AW'($urandom), DW'($urandom));
                    else req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        RST = 1'b0;
        req_valid = '0;
        repeat (GC + 6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
